// File: rtl/decade_timer_ctrl_if.sv
// Command/status bundle for decade_timer_ctrl: the master issues commands and
// a BCD target, the slave (the timer) returns count, state, busy and done.
interface decade_timer_ctrl_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic                  stop;
    logic                  clr;
    logic                  tick;
    logic [4*DIGITS-1:0]   target;
    logic [4*DIGITS-1:0]   count;
    logic [1:0]            state;
    logic                  busy;
    logic                  done;

    modport master (
        output start, stop, clr, tick, target,
        input  count, state, busy, done
    );

    modport slave (
        input  start, stop, clr, tick, target,
        output count, state, busy, done
    );
endinterface

// File: rtl/decade_timer_ctrl.sv
// Programmable BCD decade timer sequencing cascaded MOD-10 digits.
// Optional macro AUTO_RELOAD_EN: terminal tick reloads zero and stays in RUN.
module decade_timer_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    decade_timer_ctrl_if.slave    bus
);
    localparam int W = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic [1:0]   r_state;
    logic [W-1:0] r_count;
    logic [W-1:0] r_target;
    logic         r_done;

    logic [1:0]   w_state_nxt;
    logic [W-1:0] w_count_nxt;
    logic [W-1:0] w_target_nxt;
    logic         w_done_nxt;
    logic [W-1:0] w_count_inc;

    // Ripple-carry BCD increment; all-9s wraps to all-0s.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic [3:0]   dig;
        logic         carry;
        res   = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            dig = v[4*d +: 4];
            if (carry) begin
                if (dig >= 4'd9) begin
                    dig = 4'd0;
                end else begin
                    dig   = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            res[4*d +: 4] = dig;
        end
        return res;
    endfunction

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] res;
        for (int d = 0; d < DIGITS; d++) begin
            res[4*d +: 4] = (v[4*d +: 4] > 4'd9) ? 4'd9 : v[4*d +: 4];
        end
        return res;
    endfunction

    assign w_count_inc = bcd_inc(r_count);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Priority CLR > STOP > START > TICK is encoded by the if/else ordering.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_target_nxt = r_target;
        w_done_nxt   = 1'b0;
        if (bus.clr) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        w_target_nxt = bcd_clamp(bus.target);
                        w_count_nxt  = '0;
                        w_state_nxt  = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        w_state_nxt = S_PAUSE;
                    end else if (bus.tick) begin
                        w_count_nxt = w_count_inc;
                        if (w_count_inc == r_target) begin
                            w_done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                            w_count_nxt = '0;
`else
                            w_state_nxt = S_DONE;
`endif
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.count = r_count;
        bus.state = r_state;
        bus.busy  = (r_state == S_RUN) || (r_state == S_PAUSE);
        bus.done  = r_done;
    end
endmodule

// File: doc/decade_timer_ctrl.md
# decade_timer_ctrl

Controller that sequences a chain of cascaded MOD-10 (BCD) digit counters as a programmable decade timer. It captures a BCD target, counts qualified TICK pulses in BCD, pauses and resumes on command, and flags completion when the count reaches the target. It sits between the system command interface and the digit counters, owning their enable, clear and carry sequencing.

## Interface
- DIGITS, default 2: number of cascaded BCD digits, 1 to 4.
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-low reset.
- START  input  1  start from IDLE/DONE (captures TARGET) or resume from PAUSE.
- STOP  input  1  pause counting while in RUN.
- CLR  input  1  abort: return to IDLE and clear the count.
- TICK  input  1  count-enable pulse; one increment per cycle high while in RUN.
- TARGET  input  4*DIGITS  BCD terminal value; digit[3:0] is least significant.
- COUNT  output  4*DIGITS  current BCD count, registered.
- STATE  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
- BUSY  output  1  high in RUN or PAUSE.
- DONE  output  1  single-cycle completion pulse, registered.

## Operation
- Input priority within a cycle: CLR > STOP > START > TICK.
- CLR in any state: next state IDLE, COUNT=0, DONE=0.
- IDLE: START captures TARGET into target_q, sets COUNT=0 and enters RUN. All other inputs are ignored.
- Target capture: any TARGET digit >9 is clamped to 9 in target_q.
- RUN:
  - STOP: enter PAUSE. COUNT holds and any TICK that cycle is dropped.
  - TICK: perform a BCD increment. Each digit wraps 9 to 0 and carries into the next digit. The full count wraps from all-9s to all-0s.
  - If the incremented value equals target_q, DONE pulses.
- PAUSE: START returns to RUN without recapturing TARGET or clearing COUNT. STOP and TICK are ignored.
- DONE state: COUNT holds target_q. START recaptures TARGET, clears COUNT and enters RUN. STOP and TICK are ignored.
- target_q=0 means a full period: 10^DIGITS ticks, completing on the all-9s-to-0 wrap.
- START while already in RUN is ignored.

## Timing
- Reset (RESET=0 at a rising edge): STATE=IDLE, COUNT=0, target_q=0, BUSY=0, DONE=0. This applies in every state, including mid-RUN.
- Command latency: one cycle. A START sampled at edge n gives STATE=RUN and BUSY=1 after edge n.
- Count latency: one cycle. A TICK sampled at edge n updates COUNT after edge n.
- Completion: DONE goes high in the cycle after the terminal TICK edge and stays high for exactly one cycle. COUNT equals the terminal value in that same cycle.
- No combinational path exists from inputs to outputs.

## Configuration
- AUTO_RELOAD_EN defined:
  - The terminal TICK sets COUNT=0 (not target_q), pulses DONE and stays in RUN, giving periodic operation.
  - The DONE state (11) is never entered.
- AUTO_RELOAD_EN undefined:
  - The terminal TICK loads COUNT=target_q, enters the DONE state and pulses DONE once.
  - The block then waits for START or CLR.

## Test plan
All scenarios use DIGITS=2.
1. Reset: RESET=0 for 2 cycles mid-RUN at COUNT=0x37 -> COUNT=0x00, STATE=00, BUSY=0, DONE=0 after the first reset edge.
2. Basic count: TARGET=0x25, START, 25 TICKs -> COUNT passes 0x09 then 0x10. DONE is high for one cycle after the 25th TICK with COUNT=0x25 and STATE=11.
3. Pause/resume: TARGET=0x20, 5 TICKs, STOP asserted together with a TICK, 3 TICKs in PAUSE, START, 15 TICKs -> COUNT stays 0x05 through PAUSE. DONE follows the 15th post-resume TICK.
4. Full period: TARGET=0x00 -> 99 TICKs give COUNT=0x99 with DONE=0. The 100th TICK gives DONE=1 and COUNT=0x00.
5. Auto-reload (AUTO_RELOAD_EN defined): TARGET=0x03, 9 TICKs -> DONE pulses after TICKs 3, 6 and 9. COUNT is 0x00 after each pulse and STATE remains 01.
6. Priority/clamp: TARGET=0x9F captured as 0x99. CLR, STOP and TICK asserted together in RUN -> STATE=00, COUNT=0x00, no increment.
